// File: rtl/uart_cal_ctrl.sv
// Command sequencer for the UART calculator: parses "A op B =" from rx,
// launches one ALU operation and streams the result (or "E") back out through tx.
module uart_cal_ctrl #(
    parameter int W       = 16,
    parameter int MAX_DIG = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    output logic [1:0]   op_code,
    output logic         calc_start,
    input  logic         calc_done,
    input  logic [W-1:0] calc_result,
    input  logic         calc_err,
    output logic [7:0]   tx_data,
    output logic         tx_start,
    input  logic         tx_busy,
    output logic         overrun,
    output logic [2:0]   dbg_state
);

    // Handshakes: an rx byte is taken on the rising edge of the rx_valid level;
    // calc_start is a one-cycle launch answered later by a one-cycle calc_done;
    // tx_start is a one-cycle request issued only while tx_busy is low, and a
    // byte is complete once tx_busy has gone high and then low again.
    localparam int CW = $clog2(MAX_DIG + 1);
    localparam int AW = W + 4;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_CALC = 3'd2,
        S_ERR  = 3'd3,
        S_TX   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        T_ISSUE   = 2'd0,
        T_WAIT_HI = 2'd1,
        T_WAIT_LO = 2'd2
    } tx_phase_t;

    state_t      state, state_n;
    tx_phase_t   phase, phase_n;
    logic [W-1:0] acc_a, acc_a_n, acc_b, acc_b_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]  op_pend, op_pend_n;
    logic [W-1:0] op_a_n, op_b_n;
    logic [1:0]  op_code_n;
    logic [47:0] tx_buf, tx_buf_n;
    logic [2:0]  tx_left, tx_left_n;
    logic [7:0]  tx_data_n;
    logic        calc_start_n, tx_start_n, overrun_n;
    logic        rx_valid_q;

    logic        rx_acc;
    logic        is_digit, is_op, is_term, is_space;
    logic [1:0]  op_enc;
    logic [AW-1:0] acc_ext;
    logic        acc_ovf, cnt_full;
    logic [15:0] res16;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign rx_acc   = rx_valid && !rx_valid_q;
    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_op    = (rx_data == 8'h2B) || (rx_data == 8'h2D) ||
                      (rx_data == 8'h2A) || (rx_data == 8'h2F);
    assign is_term  = (rx_data == 8'h3D) || (rx_data == 8'h0D);
    assign is_space = (rx_data == 8'h20);
    assign res16    = 16'(calc_result);
    assign dbg_state = state;

    always_comb begin
        op_enc = 2'd0;
        case (rx_data)
            8'h2D:   op_enc = 2'd1;
            8'h2A:   op_enc = 2'd2;
            8'h2F:   op_enc = 2'd3;
            default: op_enc = 2'd0;
        endcase
    end

    // Widened accumulate so an out-of-range operand is rejected before it can wrap.
    assign acc_ext  = {4'h0, (state == S_A) ? acc_a : acc_b} * AW'(10) + AW'(rx_data[3:0]);
    assign acc_ovf  = |acc_ext[AW-1:W];
    assign cnt_full = (cnt == CW'(MAX_DIG));

    always_comb begin
        state_n      = state;
        phase_n      = phase;
        acc_a_n      = acc_a;
        acc_b_n      = acc_b;
        cnt_n        = cnt;
        op_pend_n    = op_pend;
        op_a_n       = op_a;
        op_b_n       = op_b;
        op_code_n    = op_code;
        tx_buf_n     = tx_buf;
        tx_left_n    = tx_left;
        tx_data_n    = tx_data;
        calc_start_n = 1'b0;
        tx_start_n   = 1'b0;
        overrun_n    = 1'b0;

        case (state)
            S_A, S_B: begin
                if (rx_acc) begin
                    if (is_digit) begin
                        if (acc_ovf || cnt_full) begin
                            state_n = S_ERR;
                        end else begin
                            if (state == S_A) acc_a_n = acc_ext[W-1:0];
                            else              acc_b_n = acc_ext[W-1:0];
                            cnt_n = cnt + CW'(1);
                        end
                    end else if (is_op) begin
                        if (state == S_A && cnt != '0) begin
                            op_pend_n = op_enc;
                            acc_b_n   = '0;
                            cnt_n     = '0;
                            state_n   = S_B;
                        end else begin
                            state_n = S_ERR;
                        end
                    end else if (is_term) begin
                        if (state == S_B && cnt != '0) begin
                            op_a_n       = acc_a;
                            op_b_n       = acc_b;
                            op_code_n    = op_pend;
                            calc_start_n = 1'b1;
                            state_n      = S_CALC;
                        end else begin
                            state_n = S_ERR;
                        end
                    end else if (!is_space) begin
                        state_n = S_ERR;
                    end
                end
            end
            S_CALC: begin
                overrun_n = rx_acc;
                if (calc_done) begin
                    if (calc_err) begin
                        state_n = S_ERR;
                    end else begin
                        tx_buf_n  = {hex_char(res16[15:12]), hex_char(res16[11:8]),
                                     hex_char(res16[7:4]), hex_char(res16[3:0]),
                                     8'h0D, 8'h0A};
                        tx_left_n = 3'd6;
                        phase_n   = T_ISSUE;
                        state_n   = S_TX;
                    end
                end
            end
            S_ERR: begin
                overrun_n = rx_acc;
                tx_buf_n  = {8'h45, 8'h0D, 8'h0A, 24'h0};
                tx_left_n = 3'd3;
                phase_n   = T_ISSUE;
                state_n   = S_TX;
            end
            S_TX: begin
                overrun_n = rx_acc;
                case (phase)
                    T_ISSUE: begin
                        if (!tx_busy) begin
                            tx_start_n = 1'b1;
                            tx_data_n  = tx_buf[47:40];
                            phase_n    = T_WAIT_HI;
                        end
                    end
                    T_WAIT_HI: begin
                        if (tx_busy) phase_n = T_WAIT_LO;
                    end
                    T_WAIT_LO: begin
                        if (!tx_busy) begin
                            tx_buf_n  = {tx_buf[39:0], 8'h00};
                            tx_left_n = tx_left - 3'd1;
                            phase_n   = T_ISSUE;
                            if (tx_left == 3'd1) begin
                                acc_a_n = '0;
                                acc_b_n = '0;
                                cnt_n   = '0;
                                state_n = S_A;
                            end
                        end
                    end
                    default: phase_n = T_ISSUE;
                endcase
            end
            default: state_n = S_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_A;
            phase      <= T_ISSUE;
            acc_a      <= '0;
            acc_b      <= '0;
            cnt        <= '0;
            op_pend    <= 2'd0;
            op_a       <= '0;
            op_b       <= '0;
            op_code    <= 2'd0;
            tx_buf     <= '0;
            tx_left    <= 3'd0;
            tx_data    <= 8'h00;
            calc_start <= 1'b0;
            tx_start   <= 1'b0;
            overrun    <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            acc_a      <= acc_a_n;
            acc_b      <= acc_b_n;
            cnt        <= cnt_n;
            op_pend    <= op_pend_n;
            op_a       <= op_a_n;
            op_b       <= op_b_n;
            op_code    <= op_code_n;
            tx_buf     <= tx_buf_n;
            tx_left    <= tx_left_n;
            tx_data    <= tx_data_n;
            calc_start <= calc_start_n;
            tx_start   <= tx_start_n;
            overrun    <= overrun_n;
            rx_valid_q <= rx_valid;
        end
    end

endmodule

// File: tb/tb_uart_cal_ctrl.sv
// Directed bench for uart_cal_ctrl: drives ASCII expressions, models the ALU
// handshake and a busy-pulsing transmitter, and checks the transmitted bytes.
module tb_uart_cal_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [W-1:0] op_a, op_b;
    logic [1:0]   op_code;
    logic         calc_start;
    logic         calc_done;
    logic [W-1:0] calc_result;
    logic         calc_err;
    logic [7:0]   tx_data;
    logic         tx_start;
    logic         tx_busy = 1'b0;
    logic         overrun;
    logic [2:0]   dbg_state;

    int checks = 0;
    int errors = 0;
    int n_calc = 0, n_tx = 0, n_ovr = 0, n_both = 0, busy_viol = 0;
    int busy_left = 0;
    int rd_ptr = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    uart_cal_ctrl #(.W(W), .MAX_DIG(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_code     (op_code),
        .calc_start  (calc_start),
        .calc_done   (calc_done),
        .calc_result (calc_result),
        .calc_err    (calc_err),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .overrun     (overrun),
        .dbg_state   (dbg_state)
    );

    always #10 clk = ~clk;

    // Event monitor and transmitter model: busy rises with tx_start, holds 5 cycles.
    always @(negedge clk) begin
        if (calc_start) n_calc++;
        if (overrun) n_ovr++;
        if (calc_start && tx_start) n_both++;
        if (tx_start) begin
            n_tx++;
            got_q.push_back(tx_data);
            if (tx_busy) busy_viol++;
            tx_busy = 1'b1;
            busy_left = 5;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_busy = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        repeat (hold) @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1);
    endtask

    task automatic wait_calc(input int target);
        for (int i = 0; i < 50 && n_calc < target; i++) @(negedge clk);
        chk("calc_start_count", 32'(n_calc), 32'(target));
    endtask

    task automatic alu_done(input logic [W-1:0] r, input logic e);
        tick(3);
        calc_done   = 1'b1;
        calc_result = r;
        calc_err    = e;
        @(negedge clk);
        calc_done   = 1'b0;
        calc_err    = 1'b0;
    endtask

    task automatic push_hex(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic push_err();
        exp_q.push_back(8'h45);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic expect_tx(input string tag);
        int n;
        logic [31:0] got;
        n = exp_q.size();
        for (int i = 0; i < 800 && !(got_q.size() >= rd_ptr + n && dbg_state == 3'd0); i++)
            @(negedge clk);
        chk({tag, "_len"}, 32'(got_q.size() - rd_ptr), 32'(n));
        chk({tag, "_idle_state"}, 32'(dbg_state), 32'd0);
        for (int j = 0; j < n; j++) begin
            got = (rd_ptr < got_q.size()) ? 32'(got_q[rd_ptr]) : 32'hDEAD;
            chk({tag, "_byte"}, got, 32'(exp_q.pop_front()));
            rd_ptr++;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_op_a"}, 32'(op_a), 32'd0);
        chk({tag, "_op_b"}, 32'(op_b), 32'd0);
        chk({tag, "_op_code"}, 32'(op_code), 32'd0);
        chk({tag, "_calc_start"}, 32'(calc_start), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        int ovr_base;
        int tx_base;
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
        calc_done = 1'b0; calc_result = '0; calc_err = 1'b0;
        tick(3);
        chk_reset_outputs("reset");
        rst = 1'b0;

        // 12+34= : add, result 0x002E, with one byte dropped mid-transmit
        send_str("12+34=");
        wait_calc(1);
        chk("t1_op_a", 32'(op_a), 32'd12);
        chk("t1_op_b", 32'(op_b), 32'd34);
        chk("t1_op_code", 32'(op_code), 32'd0);
        chk("t1_state_calc", 32'(dbg_state), 32'd2);
        alu_done(16'h002E, 1'b0);
        for (int i = 0; i < 50 && dbg_state != 3'd4; i++) @(negedge clk);
        ovr_base = n_ovr;
        send_byte(8'h39, 1);
        chk("t1_overrun", 32'(n_ovr - ovr_base), 32'd1);
        chk("t1_state_tx", 32'(dbg_state), 32'd4);
        push_hex("002E");
        expect_tx("t1");

        // 65535 * 1 CR with spaces: mul at the top of the range
        send_str("65535 * 1");
        send_byte(8'h0D, 1);
        wait_calc(2);
        chk("t2_op_a", 32'(op_a), 32'hFFFF);
        chk("t2_op_b", 32'(op_b), 32'd1);
        chk("t2_op_code", 32'(op_code), 32'd2);
        alu_done(16'hFFFF, 1'b0);
        push_hex("FFFF");
        expect_tx("t2");

        // 65536 overflows operand A; trailing bytes fall into the error transmit
        ovr_base = n_ovr;
        send_str("65536+1=");
        push_err();
        expect_tx("t3");
        chk("t3_overrun", 32'(n_ovr - ovr_base), 32'd3);
        chk("t3_no_calc", 32'(n_calc), 32'd2);

        // sixth digit exceeds the digit limit
        send_str("12345");
        chk("t4_state_5dig", 32'(dbg_state), 32'd0);
        send_byte(8'h36, 1);
        push_err();
        expect_tx("t4");
        chk("t4_no_calc", 32'(n_calc), 32'd2);

        // divide by zero reported by the ALU, then a normal subtraction
        send_str("8/0=");
        wait_calc(3);
        chk("t5_op_a", 32'(op_a), 32'd8);
        chk("t5_op_b", 32'(op_b), 32'd0);
        chk("t5_op_code", 32'(op_code), 32'd3);
        alu_done(16'h0000, 1'b1);
        push_err();
        expect_tx("t5e");
        send_str("7-2=");
        wait_calc(4);
        chk("t5_sub_op_a", 32'(op_a), 32'd7);
        chk("t5_sub_op_b", 32'(op_b), 32'd2);
        chk("t5_sub_op_code", 32'(op_code), 32'd1);
        alu_done(16'h0005, 1'b0);
        push_hex("0005");
        expect_tx("t5");

        // syntax errors: leading operator, empty B, illegal character
        send_str("+5=");
        push_err();
        expect_tx("t6a");
        send_str("5+=");
        push_err();
        expect_tx("t6b");
        send_str("5x");
        push_err();
        expect_tx("t6c");
        chk("t6_no_calc", 32'(n_calc), 32'd4);

        // rx_valid held high for three cycles yields one digit
        send_byte(8'h37, 3);
        send_str("+1=");
        wait_calc(5);
        chk("t7_op_a", 32'(op_a), 32'd7);
        chk("t7_op_b", 32'(op_b), 32'd1);
        chk("t7_op_code", 32'(op_code), 32'd0);
        alu_done(16'h0008, 1'b0);
        push_hex("0008");
        expect_tx("t7");

        // reset after two response bytes aborts the transmit
        send_str("1+1=");
        wait_calc(6);
        alu_done(16'h0002, 1'b0);
        for (int i = 0; i < 400 && got_q.size() < rd_ptr + 2; i++) @(negedge clk);
        chk("t8_first_len", 32'(got_q.size() - rd_ptr), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("t8_reset");
        rst = 1'b0;
        tx_base = n_tx;
        tick(60);
        chk("t8_no_tx_after_reset", 32'(n_tx - tx_base), 32'd0);
        rd_ptr = got_q.size();
        send_str("3*4=");
        wait_calc(7);
        chk("t8_op_a", 32'(op_a), 32'd3);
        chk("t8_op_b", 32'(op_b), 32'd4);
        chk("t8_op_code", 32'(op_code), 32'd2);
        alu_done(16'h000C, 1'b0);
        push_hex("000C");
        expect_tx("t8");

        chk("calc_tx_overlap", 32'(n_both), 32'd0);
        chk("tx_start_while_busy", 32'(busy_viol), 32'd0);
        chk("total_calc_starts", 32'(n_calc), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
